// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add multiplier feeding the HI/LO registers.
// One partial product per clock, 32 compute cycles, result and done pulse on
// the following cycle. busy_o is the pipeline stall.
// Optional feature macro: SIGNED_MUL_EN (enables MULT via magnitude multiply
// and a final two's-complement negation).
`timescale 1ns/1ps

module mul_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic             wr_hi_i,
  input  logic             wr_lo_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic [WIDTH:0]   sum_c;
  logic [PW-1:0]    shifted_c;
  logic [PW-1:0]    prod_c;

`ifdef SIGNED_MUL_EN
  logic neg_q, neg_d;
  logic neg_c;

  // Operand magnitudes and result sign for MULT; MULTU passes straight through
  always_comb begin
    mag_a_c = a_i;
    mag_b_c = b_i;
    neg_c   = 1'b0;
    if (is_signed_i) begin
      if (a_i[WIDTH-1]) mag_a_c = ~a_i + WIDTH'(1);
      if (b_i[WIDTH-1]) mag_b_c = ~b_i + WIDTH'(1);
      neg_c = a_i[WIDTH-1] ^ b_i[WIDTH-1];
    end
  end

  assign prod_c = neg_q ? (~shifted_c + PW'(1)) : shifted_c;

  // Result sign register, loaded with the operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) neg_q <= 1'b0;
    else        neg_q <= neg_d;
  end

  // Sign capture only on an accepted start
  always_comb begin
    neg_d = neg_q;
    if (state_q == IDLE && start_i && !flush_i) neg_d = neg_c;
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed_i;
  assign mag_a_c          = a_i;
  assign mag_b_c          = b_i;
  assign prod_c           = shifted_c;
`endif

  // One shift-add step: add multiplicand into the upper half, carry into bit WIDTH, shift right
  assign sum_c     = {1'b0, acc_q[PW-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign shifted_c = {sum_c, acc_q[WIDTH-1:1]};

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state, iteration control and HI/LO update
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          mcand_d  = mag_a_c;
          mplier_d = mag_b_c;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = BUSY;
        end else begin
          if (wr_hi_i) hi_d = wr_data_i;
          if (wr_lo_i) lo_d = wr_data_i;
        end
      end
      BUSY: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d    = shifted_c;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            hi_d    = prod_c[PW-1:WIDTH];
            lo_d    = prod_c[WIDTH-1:0];
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: table-driven vectors through a result
// scoreboard, plus hand sequences for flush, write collisions and async reset.
`timescale 1ns/1ps

module tb_mul_unit;

  localparam int unsigned W = 32;
`ifdef SIGNED_MUL_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic         is_signed_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         flush_i;
  logic         wr_hi_i;
  logic         wr_lo_i;
  logic [W-1:0] wr_data_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] sb_q[$];
  logic [W-1:0]   m_hi = '0;
  logic [W-1:0]   m_lo = '0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        name;
  } vec_t;

  vec_t vecs[$];

  mul_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .is_signed_i (is_signed_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .flush_i     (flush_i),
    .wr_hi_i     (wr_hi_i),
    .wr_lo_i     (wr_lo_i),
    .wr_data_i   (wr_data_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    if (s && SEN) return 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Drive a start for one cycle and record the expected product
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [63:0] exp, input string tag);
    a_i         = a;
    b_i         = b;
    is_signed_i = s;
    start_i     = 1'b1;
    sb_q.push_back(exp);
    tick();
    start_i     = 1'b0;
    is_signed_i = 1'b0;
    check({tag, " busy after start"}, 64'(busy_o), 64'd1);
  endtask

  // Wait for done; 'elapsed' is cycles already spent after the start edge
  task automatic wait_done(input int elapsed, input string tag);
    int          busy_cnt = 0;
    bit          seen     = 1'b0;
    bit          moved    = 1'b0;
    logic [63:0] exp;
    for (int k = elapsed + 1; k <= 40; k++) begin
      tick();
      if (done_o) begin
        seen = 1'b1;
        check({tag, " latency"}, 64'(k), 64'd32);
        check({tag, " busy at done"}, 64'(busy_o), 64'd0);
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(31 - elapsed));
        check({tag, " hi/lo held while busy"}, 64'(moved), 64'd0);
        check({tag, " scoreboard depth"}, 64'(sb_q.size()), 64'd1);
        if (sb_q.size() != 0) begin
          exp = sb_q.pop_front();
          check({tag, " product"}, {hi_o, lo_o}, exp);
          m_hi = exp[63:32];
          m_lo = exp[31:0];
        end
        break;
      end
      if (busy_o) busy_cnt++;
      if ({hi_o, lo_o} !== {m_hi, m_lo}) moved = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: done not seen, busy=%0b", tag, busy_o);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    bit           bad;

    rst_n = 1'b0; start_i = 1'b0; is_signed_i = 1'b0; a_i = '0; b_i = '0;
    flush_i = 1'b0; wr_hi_i = 1'b0; wr_lo_i = 1'b0; wr_data_i = '0;
    repeat (3) tick();
    check("reset hi", 64'(hi_o), 64'd0);
    check("reset lo", 64'(lo_o), 64'd0);
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset done", 64'(done_o), 64'd0);
    rst_n = 1'b1;
    tick();

    vecs.push_back('{32'd7, 32'd6, 1'b0, 32'h0, 32'h2A, "7x6"});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h1, "umax"});
    vecs.push_back('{32'hFFFFFFFE, 32'd3, 1'b1, SEN ? 32'hFFFFFFFF : 32'h2, 32'hFFFFFFFA, "-2x3"});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, SEN ? 32'h0 : 32'hFFFFFFFE, 32'h1, "-1x-1"});
    vecs.push_back('{32'h0, 32'h12345678, 1'b0, 32'h0, 32'h0, "zero"});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h0, "msb sq"});
    vecs.push_back('{32'h80000000, 32'd2, 1'b1, SEN ? 32'hFFFFFFFF : 32'h1, 32'h0, "minint x2"});
    vecs.push_back('{32'h0000FFFF, 32'h00010001, 1'b0, 32'h0, 32'hFFFFFFFF, "ffff"});

    // Back-to-back: each new start lands in the previous done cycle
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].s, {vecs[i].hi, vecs[i].lo}, vecs[i].name);
      wait_done(0, vecs[i].name);
    end
    tick();
    check("done is one pulse", 64'(done_o), 64'd0);
    check("hi/lo hold after done", {hi_o, lo_o}, {m_hi, m_lo});

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      start_op(ra, rb, rs, model(ra, rb, rs), "rand");
      wait_done(0, "rand");
    end

    // Preload HI/LO, then flush a 5x5 at cycle 10
    tick();
    wr_data_i = 32'h11111111; wr_hi_i = 1'b1; tick(); wr_hi_i = 1'b0;
    wr_data_i = 32'h22222222; wr_lo_i = 1'b1; tick(); wr_lo_i = 1'b0;
    m_hi = 32'h11111111; m_lo = 32'h22222222;
    check("mthi", 64'(hi_o), 64'(m_hi));
    check("mtlo", 64'(lo_o), 64'(m_lo));
    a_i = 32'd5; b_i = 32'd5; start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (9) tick();
    check("busy before flush", 64'(busy_o), 64'd1);
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    check("busy after flush", 64'(busy_o), 64'd0);
    bad = 1'b0;
    repeat (40) begin
      tick();
      if (done_o || busy_o) bad = 1'b1;
    end
    check("no done after flush", 64'(bad), 64'd0);
    check("hi/lo after flush", {hi_o, lo_o}, {m_hi, m_lo});

    // MTLO during BUSY is ignored
    start_op(32'd3, 32'd4, 1'b0, 64'd12, "wrlo busy");
    repeat (5) tick();
    wr_data_i = 32'h0000DEAD; wr_lo_i = 1'b1; tick(); wr_lo_i = 1'b0;
    check("lo during busy write", 64'(lo_o), 64'(m_lo));
    wait_done(6, "wrlo busy");

    // Start and MTHI together: write dropped, multiply runs
    wr_data_i = 32'h00000BAD; wr_hi_i = 1'b1;
    start_op(32'd2, 32'd2, 1'b0, 64'd4, "start+wrhi");
    wr_hi_i = 1'b0;
    check("hi after start+wrhi", 64'(hi_o), 64'(m_hi));
    wait_done(0, "start+wrhi");

    // Start and flush together: nothing starts
    a_i = 32'd3; b_i = 32'd3; start_i = 1'b1; flush_i = 1'b1; tick();
    start_i = 1'b0; flush_i = 1'b0;
    check("start+flush busy", 64'(busy_o), 64'd0);
    bad = 1'b0;
    repeat (35) begin
      tick();
      if (done_o || busy_o) bad = 1'b1;
    end
    check("start+flush no op", 64'(bad), 64'd0);
    check("start+flush hi/lo", {hi_o, lo_o}, {m_hi, m_lo});

    // MTHI and MTLO together
    wr_data_i = 32'hCAFEF00D; wr_hi_i = 1'b1; wr_lo_i = 1'b1; tick();
    wr_hi_i = 1'b0; wr_lo_i = 1'b0;
    m_hi = 32'hCAFEF00D; m_lo = 32'hCAFEF00D;
    check("mthi+mtlo", {hi_o, lo_o}, {m_hi, m_lo});

    // Async reset at cycle 15 of BUSY, observed between clock edges
    a_i = 32'd9; b_i = 32'd9; start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (15) tick();
    check("busy before async reset", 64'(busy_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset busy", 64'(busy_o), 64'd0);
    check("async reset hi", 64'(hi_o), 64'd0);
    check("async reset lo", 64'(lo_o), 64'd0);
    m_hi = '0; m_lo = '0;
    #2;
    rst_n = 1'b1;
    tick();
    start_op(32'd2, 32'd3, 1'b0, 64'd6, "2x3 after reset");
    wait_done(0, "2x3 after reset");

    check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
